// File: rtl/rx_dll_pkg.sv
// Shared types and helpers for the receive-side data link layer:
// DLLP type codes, DLLP word layout, ACK/NAK FSM states and the
// modular sequence-distance helper.
package rx_dll_pkg;

   // Widest sequence number the DLLP word can carry.
   localparam int SEQ_MAX_W = 24;

   localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
   localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

   // DLLP word: type byte on top, AckNak_Seq zero-extended below it.
   // Bits above SEQ_W in the seq field are the reserved (zero) bits.
   typedef struct packed {
      logic [7:0]           dtype;
      logic [SEQ_MAX_W-1:0] seq;
   } dllp_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_ACK = 2'd1,
      SEND_NAK = 2'd2
   } dllp_state_e;

   // (a - b) mod 2^w, for w in 1..SEQ_MAX_W.
   function automatic logic [SEQ_MAX_W-1:0] seq_dist(
      input logic [SEQ_MAX_W-1:0] a,
      input logic [SEQ_MAX_W-1:0] b,
      input int                   w
   );
      logic [SEQ_MAX_W-1:0] mask;
      if (w >= SEQ_MAX_W) begin
         mask = {SEQ_MAX_W{1'b1}};
      end else begin
         mask = (SEQ_MAX_W'(1) << w) - SEQ_MAX_W'(1);
      end
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/rx_tlp_fifo.sv
// First-word-fall-through TLP buffer. The head entry is visible on o_data
// whenever o_empty is low. A push while full is taken only together with a pop.
module rx_tlp_fifo #(
   parameter int DATA_W     = 1024,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]   LP_DEPTH = (AW+1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == LP_DEPTH);
   assign o_empty   = (r_count == '0);
   assign o_data    = r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage array: data only, never reset.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rx_dll_ack_nak.sv
// Receive data link layer: sequence checking of incoming TLPs, in-order
// forwarding through a FWFT buffer, and coalesced ACK/NAK DLLP generation.
module rx_dll_ack_nak
   import rx_dll_pkg::*;
#(
   parameter int DATA_W      = 1024,
   parameter int SEQ_W       = 12,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tlp_data_in,
   input  logic [SEQ_W-1:0]  tlp_seq_in,
   input  logic              tlp_crc_ok_in,
   input  logic              tlp_valid_in,
   output logic              tlp_ready_out,
   output logic [DATA_W-1:0] tlp_data_out,
   output logic              tlp_valid_out,
   input  logic              tlp_ready_in,
   output logic [31:0]       dllp_o,
   output logic              dllp_valid,
   input  logic              dllp_ready
);

   localparam int                   TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0]        LP_TMAX = TW'(ACK_TIMEOUT - 1);
   localparam logic [SEQ_MAX_W-1:0] LP_HALF = SEQ_MAX_W'(1) << (SEQ_W - 1);

   logic                 w_ready;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_accept;
   logic [SEQ_MAX_W-1:0] w_dist;
   logic                 w_good;
   logic                 w_dup;
   logic                 w_ahead;
   logic                 w_bad;
   logic                 w_nak_evt;
   logic                 w_timer_run;
   logic                 w_timeout;
   logic                 w_load_ack;
   logic                 w_load_nak;
   logic                 w_load;
   logic                 w_dllp_valid;
   logic [SEQ_W-1:0]     w_ack_seq;
   dllp_t                w_dllp_load;
   dllp_state_e          w_state_nxt;

   logic                 r_run;
   logic [SEQ_W-1:0]     r_nrs;
   logic                 r_ack_pending;
   logic                 r_nak_sched;
   logic                 r_ack_req;
   logic                 r_nak_req;
   logic [TW-1:0]        r_timer;
   dllp_state_e          r_state;
   dllp_t                r_dllp;

   // r_run keeps the input closed for the first cycle after reset.
   assign w_ready       = r_run && !w_full;
   assign tlp_ready_out = w_ready;
   assign tlp_valid_out = !w_empty;
   assign w_pop         = !w_empty && tlp_ready_in;
   assign dllp_valid    = w_dllp_valid;
   assign dllp_o        = r_dllp;

   rx_tlp_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_good),
      .i_data  (tlp_data_in),
      .i_pop   (w_pop),
      .o_data  (tlp_data_out),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Classify an accepted TLP by CRC verdict and distance behind NRS.
   always_comb begin
      w_accept  = tlp_valid_in && w_ready;
      w_dist    = seq_dist(SEQ_MAX_W'(r_nrs), SEQ_MAX_W'(tlp_seq_in), SEQ_W);
      w_bad     = w_accept && !tlp_crc_ok_in;
      w_good    = w_accept && tlp_crc_ok_in && (w_dist == '0);
      w_dup     = w_accept && tlp_crc_ok_in && (w_dist != '0) && (w_dist <= LP_HALF);
      w_ahead   = w_accept && tlp_crc_ok_in && (w_dist > LP_HALF);
      w_nak_evt = (w_bad || w_ahead) && !r_nak_sched;
   end

   // Input gate opens one cycle after reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // Next receive sequence, NAK suppression and pending-acknowledge tracking.
   // A good TLP in the load cycle wins over the clear, so ack_pending re-arms.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nrs         <= '0;
         r_nak_sched   <= 1'b0;
         r_ack_pending <= 1'b0;
      end else begin
         if (w_good) begin
            r_nrs <= r_nrs + SEQ_W'(1);
         end
         if (w_good) begin
            r_nak_sched <= 1'b0;
         end else if (w_nak_evt) begin
            r_nak_sched <= 1'b1;
         end
         if (w_good) begin
            r_ack_pending <= 1'b1;
         end else if (w_load) begin
            r_ack_pending <= 1'b0;
         end
      end
   end

   // ACK timer: runs while an acknowledge is owed and the DLLP channel is idle.
   always_comb begin
      w_timer_run = r_ack_pending && (r_state == IDLE) && !w_load;
      w_timeout   = w_timer_run && (r_timer == LP_TMAX);
   end

   // Timer register, cleared by any DLLP load and parked at the threshold.
   always_ff @(posedge clk) begin
      if (reset || w_load) begin
         r_timer <= '0;
      end else if (w_timer_run && (r_timer != LP_TMAX)) begin
         r_timer <= r_timer + TW'(1);
      end
   end

   // Single-entry request latches; repeated requests merge, a NAK load
   // also retires any waiting ACK request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack_req <= 1'b0;
         r_nak_req <= 1'b0;
      end else begin
         r_ack_req <= (r_ack_req && !w_load) || w_dup || w_timeout;
         r_nak_req <= (r_nak_req && !w_load_nak) || w_nak_evt;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: NAK has priority over ACK.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_nak_req) begin
               w_state_nxt = SEND_NAK;
            end else if (r_ack_req) begin
               w_state_nxt = SEND_ACK;
            end
         end
         SEND_ACK, SEND_NAK: begin
            if (dllp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs: load strobes on entry to a SEND state, valid while in one.
   always_comb begin
      w_load_nak   = (r_state == IDLE) && r_nak_req;
      w_load_ack   = (r_state == IDLE) && !r_nak_req && r_ack_req;
      w_load       = w_load_nak || w_load_ack;
      w_dllp_valid = (r_state != IDLE);
   end

   // DLLP word assembled from NRS as it stands before this cycle's update.
   always_comb begin
      w_ack_seq         = r_nrs - SEQ_W'(1);
      w_dllp_load.dtype = w_load_nak ? DLLP_TYPE_NAK : DLLP_TYPE_ACK;
      w_dllp_load.seq   = SEQ_MAX_W'(w_ack_seq);
   end

   // DLLP output register, held stable until the next load.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dllp <= '0;
      end else if (w_load) begin
         r_dllp <= w_dllp_load;
      end
   end

endmodule

// File: tb/tb_rx_dll_ack_nak.sv
// Directed bench for rx_dll_ack_nak with DATA_W=32, SEQ_W=4, FIFO_DEPTH=4,
// ACK_TIMEOUT=8. Each task drives one scenario and checks its own results.
module tb_rx_dll_ack_nak;

   logic        clk;
   logic        reset;
   logic [31:0] tlp_data_in;
   logic [3:0]  tlp_seq_in;
   logic        tlp_crc_ok_in;
   logic        tlp_valid_in;
   logic        tlp_ready_out;
   logic [31:0] tlp_data_out;
   logic        tlp_valid_out;
   logic        tlp_ready_in;
   logic [31:0] dllp_o;
   logic        dllp_valid;
   logic        dllp_ready;

   int          errors;
   int          checks;
   logic [31:0] dllp_q[$];
   logic [31:0] out_q[$];

   rx_dll_ack_nak #(
      .DATA_W      (32),
      .SEQ_W       (4),
      .FIFO_DEPTH  (4),
      .ACK_TIMEOUT (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tlp_data_in   (tlp_data_in),
      .tlp_seq_in    (tlp_seq_in),
      .tlp_crc_ok_in (tlp_crc_ok_in),
      .tlp_valid_in  (tlp_valid_in),
      .tlp_ready_out (tlp_ready_out),
      .tlp_data_out  (tlp_data_out),
      .tlp_valid_out (tlp_valid_out),
      .tlp_ready_in  (tlp_ready_in),
      .dllp_o        (dllp_o),
      .dllp_valid    (dllp_valid),
      .dllp_ready    (dllp_ready)
   );

   always #5 clk = ~clk;

   // Record every completed handshake on both output channels.
   always @(posedge clk) begin
      if (!reset) begin
         if (dllp_valid && dllp_ready) dllp_q.push_back(dllp_o);
         if (tlp_valid_out && tlp_ready_in) out_q.push_back(tlp_data_out);
      end
   end

   function automatic logic [31:0] tdata(input logic [3:0] s);
      return 32'hC0DE_0000 | 32'(s);
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one TLP and return at #1 after the edge that accepted it.
   task automatic send_tlp(input logic [3:0] s, input logic ok);
      logic acc;
      acc           = 1'b0;
      tlp_seq_in    = s;
      tlp_crc_ok_in = ok;
      tlp_data_in   = tdata(s);
      tlp_valid_in  = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (tlp_ready_out) acc = 1'b1;
         step(1);
      end
      tlp_valid_in = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_tlp seq %0d: not accepted within 50 cycles", s);
      end
   endtask

   task automatic wait_dllps(input int n, input int max_cycles);
      for (int i = 0; i < max_cycles && dllp_q.size() < n; i++) step(1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      dllp_q.delete();
      out_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      checks++;
      if (tlp_valid_out !== 1'b0) begin errors++; $display("FAIL rst_tlp_valid: got %b want 0", tlp_valid_out); end
      checks++;
      if (tlp_ready_out !== 1'b0) begin errors++; $display("FAIL rst_tlp_ready: got %b want 0", tlp_ready_out); end
      checks++;
      if (dllp_valid !== 1'b0) begin errors++; $display("FAIL rst_dllp_valid: got %b want 0", dllp_valid); end
      checks++;
      if (dllp_o !== 32'h0) begin errors++; $display("FAIL rst_dllp_o: got %h want 0", dllp_o); end
      reset = 1'b0;
      checks++;
      if (tlp_ready_out !== 1'b0) begin errors++; $display("FAIL rst_after_ready: got %b want 0", tlp_ready_out); end
      checks++;
      if (dllp_valid !== 1'b0) begin errors++; $display("FAIL rst_after_dllp_valid: got %b want 0", dllp_valid); end
      step(1);
      checks++;
      if (tlp_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready_open: got %b want 1", tlp_ready_out); end
      checks++;
      if (dllp_o !== 32'h0) begin errors++; $display("FAIL rst_idle_dllp_o: got %h want 0", dllp_o); end
   endtask

   task automatic test_in_order();
      do_reset();
      tlp_ready_in = 1'b1;
      dllp_ready   = 1'b1;
      for (int s = 0; s < 3; s++) begin
         send_tlp(4'(s), 1'b1);
         checks++;
         if (tlp_valid_out !== 1'b1 || tlp_data_out !== tdata(4'(s)))
         begin
            errors++;
            $display("FAIL inorder_fwd seq %0d: got valid=%b data=%h want valid=1 data=%h",
                     s, tlp_valid_out, tlp_data_out, tdata(4'(s)));
         end
      end
      wait_dllps(1, 30);
      step(20);
      checks++;
      if (dllp_q.size() !== 1) begin
         errors++;
         $display("FAIL inorder_ack_count: got %0d want 1", dllp_q.size());
      end else begin
         checks++;
         if (dllp_q[0] !== 32'h0000_0002) begin errors++; $display("FAIL inorder_ack: got %h want 00000002", dllp_q[0]); end
      end
      checks++;
      if (out_q.size() !== 3) begin
         errors++;
         $display("FAIL inorder_out_count: got %0d want 3", out_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_q[i] !== tdata(4'(i))) begin errors++; $display("FAIL inorder_out[%0d]: got %h want %h", i, out_q[i], tdata(4'(i))); end
         end
      end
   endtask

   task automatic test_crc_error();
      do_reset();
      send_tlp(4'd0, 1'b1);
      send_tlp(4'd1, 1'b0);
      send_tlp(4'd2, 1'b1);
      step(12);
      checks++;
      if (dllp_q.size() !== 1) begin
         errors++;
         $display("FAIL crc_nak_count: got %0d want 1", dllp_q.size());
      end else begin
         checks++;
         if (dllp_q[0] !== 32'h1000_0000) begin errors++; $display("FAIL crc_nak: got %h want 10000000", dllp_q[0]); end
      end
      checks++;
      if (out_q.size() !== 1) begin errors++; $display("FAIL crc_out_count: got %0d want 1", out_q.size()); end
      send_tlp(4'd1, 1'b1);
      wait_dllps(2, 30);
      step(2);
      checks++;
      if (dllp_q.size() !== 2) begin
         errors++;
         $display("FAIL crc_ack_count: got %0d want 2", dllp_q.size());
      end else begin
         checks++;
         if (dllp_q[1] !== 32'h0000_0001) begin errors++; $display("FAIL crc_ack: got %h want 00000001", dllp_q[1]); end
      end
      checks++;
      if (out_q.size() !== 2) begin
         errors++;
         $display("FAIL crc_resend_count: got %0d want 2", out_q.size());
      end else begin
         checks++;
         if (out_q[1] !== tdata(4'd1)) begin errors++; $display("FAIL crc_resend_data: got %h want %h", out_q[1], tdata(4'd1)); end
      end
   endtask

   task automatic test_duplicate();
      do_reset();
      for (int s = 0; s < 5; s++) send_tlp(4'(s), 1'b1);
      send_tlp(4'd3, 1'b1);
      wait_dllps(1, 3);
      checks++;
      if (dllp_q.size() !== 1) begin
         errors++;
         $display("FAIL dup_ack_immediate: got %0d DLLPs want 1", dllp_q.size());
      end else begin
         checks++;
         if (dllp_q[0] !== 32'h0000_0004) begin errors++; $display("FAIL dup_ack: got %h want 00000004", dllp_q[0]); end
      end
      step(15);
      checks++;
      if (dllp_q.size() !== 1) begin errors++; $display("FAIL dup_extra_dllp: got %0d want 1", dllp_q.size()); end
      checks++;
      if (out_q.size() !== 5) begin errors++; $display("FAIL dup_forwarded: got %0d want 5", out_q.size()); end
   endtask

   task automatic test_wrap_backpressure();
      logic [3:0] exp_seq [4];
      exp_seq = '{4'd14, 4'd15, 4'd0, 4'd1};
      do_reset();
      for (int s = 0; s < 14; s++) send_tlp(4'(s), 1'b1);
      step(20);
      dllp_q.delete();
      out_q.delete();
      tlp_ready_in = 1'b0;
      for (int i = 0; i < 4; i++) send_tlp(exp_seq[i], 1'b1);
      checks++;
      if (tlp_ready_out !== 1'b0) begin errors++; $display("FAIL wrap_full_ready: got %b want 0", tlp_ready_out); end
      checks++;
      if (tlp_valid_out !== 1'b1 || tlp_data_out !== tdata(4'd14)) begin
         errors++;
         $display("FAIL wrap_head: got valid=%b data=%h want valid=1 data=%h", tlp_valid_out, tlp_data_out, tdata(4'd14));
      end
      step(3);
      checks++;
      if (tlp_ready_out !== 1'b0) begin errors++; $display("FAIL wrap_hold_ready: got %b want 0", tlp_ready_out); end
      tlp_ready_in = 1'b1;
      step(1);
      checks++;
      if (tlp_ready_out !== 1'b1) begin errors++; $display("FAIL wrap_ready_after_pop: got %b want 1", tlp_ready_out); end
      step(6);
      checks++;
      if (out_q.size() !== 4) begin
         errors++;
         $display("FAIL wrap_out_count: got %0d want 4", out_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_q[i] !== tdata(exp_seq[i])) begin errors++; $display("FAIL wrap_out[%0d]: got %h want %h", i, out_q[i], tdata(exp_seq[i])); end
         end
      end
      wait_dllps(1, 30);
      step(12);
      checks++;
      if (dllp_q.size() !== 1) begin
         errors++;
         $display("FAIL wrap_ack_count: got %0d want 1", dllp_q.size());
      end else begin
         checks++;
         if (dllp_q[0] !== 32'h0000_0001) begin errors++; $display("FAIL wrap_ack: got %h want 00000001", dllp_q[0]); end
      end
   endtask

   task automatic test_dllp_backpressure();
      int bad_cycles;
      do_reset();
      dllp_ready = 1'b0;
      send_tlp(4'd0, 1'b1);
      send_tlp(4'd1, 1'b1);
      send_tlp(4'd0, 1'b1);
      for (int i = 0; i < 6 && !dllp_valid; i++) step(1);
      checks++;
      if (dllp_valid !== 1'b1 || dllp_o !== 32'h0000_0001) begin
         errors++;
         $display("FAIL bp_ack_held: got valid=%b dllp=%h want valid=1 dllp=00000001", dllp_valid, dllp_o);
      end
      send_tlp(4'd2, 1'b0);
      bad_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (dllp_valid !== 1'b1 || dllp_o !== 32'h0000_0001) bad_cycles++;
      end
      checks++;
      if (bad_cycles !== 0) begin errors++; $display("FAIL bp_ack_stable: got %0d unstable cycles want 0", bad_cycles); end
      dllp_ready = 1'b1;
      step(1);
      dllp_ready = 1'b0;
      for (int i = 0; i < 6 && !dllp_valid; i++) step(1);
      bad_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         if (dllp_valid !== 1'b1 || dllp_o !== 32'h1000_0001) bad_cycles++;
         step(1);
      end
      checks++;
      if (bad_cycles !== 0) begin errors++; $display("FAIL bp_nak_stable: got %0d bad cycles dllp=%h want 0 with 10000001", bad_cycles, dllp_o); end
      dllp_ready = 1'b1;
      step(15);
      checks++;
      if (dllp_q.size() !== 2) begin
         errors++;
         $display("FAIL bp_dllp_count: got %0d want 2", dllp_q.size());
      end else begin
         checks++;
         if (dllp_q[0] !== 32'h0000_0001 || dllp_q[1] !== 32'h1000_0001) begin
            errors++;
            $display("FAIL bp_order: got %h,%h want 00000001,10000001", dllp_q[0], dllp_q[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tlp_ready_in = 1'b0;
      dllp_ready   = 1'b0;
      send_tlp(4'd0, 1'b1);
      send_tlp(4'd1, 1'b1);
      send_tlp(4'd0, 1'b1);
      for (int i = 0; i < 6 && !dllp_valid; i++) step(1);
      checks++;
      if (dllp_valid !== 1'b1 || tlp_valid_out !== 1'b1) begin
         errors++;
         $display("FAIL midrst_setup: got dllp_valid=%b tlp_valid=%b want 1,1", dllp_valid, tlp_valid_out);
      end
      reset = 1'b1;
      step(1);
      checks++;
      if ({tlp_valid_out, tlp_ready_out, dllp_valid} !== 3'b000 || dllp_o !== 32'h0) begin
         errors++;
         $display("FAIL midrst_during: got tv=%b tr=%b dv=%b dllp=%h want all 0",
                  tlp_valid_out, tlp_ready_out, dllp_valid, dllp_o);
      end
      reset = 1'b0;
      checks++;
      if ({tlp_valid_out, tlp_ready_out, dllp_valid} !== 3'b000 || dllp_o !== 32'h0) begin
         errors++;
         $display("FAIL midrst_after: got tv=%b tr=%b dv=%b dllp=%h want all 0",
                  tlp_valid_out, tlp_ready_out, dllp_valid, dllp_o);
      end
      dllp_ready   = 1'b1;
      tlp_ready_in = 1'b1;
      dllp_q.delete();
      out_q.delete();
      step(20);
      checks++;
      if (dllp_q.size() !== 0 || out_q.size() !== 0) begin
         errors++;
         $display("FAIL midrst_stale: got %0d DLLPs %0d TLPs want 0,0", dllp_q.size(), out_q.size());
      end
      send_tlp(4'd0, 1'b1);
      checks++;
      if (tlp_valid_out !== 1'b1 || tlp_data_out !== tdata(4'd0)) begin
         errors++;
         $display("FAIL midrst_seq0: got valid=%b data=%h want valid=1 data=%h", tlp_valid_out, tlp_data_out, tdata(4'd0));
      end
      wait_dllps(1, 30);
      checks++;
      if (dllp_q.size() !== 1) begin
         errors++;
         $display("FAIL midrst_ack_count: got %0d want 1", dllp_q.size());
      end else begin
         checks++;
         if (dllp_q[0] !== 32'h0000_0000) begin errors++; $display("FAIL midrst_ack: got %h want 00000000", dllp_q[0]); end
      end
   endtask

   initial begin
      clk           = 1'b0;
      reset         = 1'b1;
      tlp_data_in   = '0;
      tlp_seq_in    = '0;
      tlp_crc_ok_in = 1'b0;
      tlp_valid_in  = 1'b0;
      tlp_ready_in  = 1'b1;
      dllp_ready    = 1'b1;
      errors        = 0;
      checks        = 0;
      test_reset();
      test_in_order();
      test_crc_error();
      test_duplicate();
      test_wrap_backpressure();
      test_dllp_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
